// File: rtl/ms_pkg.sv
// ms_pkg: shared state encodings for the MS span queue
package ms_pkg;
    typedef enum logic [1:0] {
        MS_SQ_IDLE = 2'd0,
        MS_SQ_LOAD = 2'd1,
        MS_SQ_HOLD = 2'd2
    } ms_sq_state_e;
endpackage

// File: rtl/ms_sq_regfile.sv
// ms_sq_regfile: DEPTH x SIZE storage, one write port, one async read port, no reset
module ms_sq_regfile #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [SIZE-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [SIZE-1:0] rdata
);
    logic [SIZE-1:0] mem [DEPTH];
    // write the addressed entry; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/ms_span_queue.sv
// ms_span_queue: span word queue feeding the ms_latch_h capture stage with ack handshake
module ms_span_queue
    import ms_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            wr_valid,
    input  logic [SIZE-1:0] wr_data,
    output logic            wr_ready,
    output logic            lat_e,
    output logic [SIZE-1:0] lat_d,
    input  logic            ld_ack,
    output logic [AW:0]     count,
    output logic            empty
);
    ms_sq_state_e    state_q, state_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic            lat_e_q, lat_e_d;
    logic [SIZE-1:0] lat_d_q, lat_d_d;
    logic [SIZE-1:0] rd_data;
    logic            full, push, pop;

    ms_sq_regfile #(.SIZE(SIZE), .DEPTH(DEPTH), .AW(AW)) u_rf (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_data)
    );

    assign count    = wr_ptr_q - rd_ptr_q;
    assign empty    = count == '0;
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wr_ready = !full;
    assign lat_e    = lat_e_q;
    assign lat_d    = lat_d_q;

    // pop decision, pointer advance and next FSM state; flush beats push and pop
    always_comb begin
        push     = wr_valid && !full && !flush;
        pop      = !flush && !empty && (state_q == MS_SQ_IDLE || (state_q == MS_SQ_HOLD && ld_ack));
        wr_ptr_d = flush ? '0 : wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = flush ? '0 : rd_ptr_q + {{AW{1'b0}}, pop};
        lat_e_d  = pop;
        lat_d_d  = pop ? rd_data : lat_d_q;
        state_d  = flush                                   ? MS_SQ_IDLE :
                   pop                                     ? MS_SQ_LOAD :
                   state_q == MS_SQ_LOAD                   ? MS_SQ_HOLD :
                   (state_q == MS_SQ_HOLD && ld_ack)       ? MS_SQ_IDLE : state_q;
    end

    // state, pointers and registered latch outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= MS_SQ_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lat_e_q  <= 1'b0;
            lat_d_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            lat_e_q  <= lat_e_d;
            lat_d_q  <= lat_d_d;
        end
    end
endmodule
